coffee_ctrl: RTL

COFFEE_CTRL -- requirements
Module: coffee_ctrl

---
 rtl/coffee_pkg.sv | 18 +
 rtl/coffee_if.sv | 26 ++
 rtl/coffee_brew_timer.sv | 43 ++++
 rtl/coffee_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee vending controller: state codes,
// default pricing constants and the balance datapath width.
package coffee_pkg;

    localparam int BAL_W = 14;

    localparam int unsigned DEF_COIN_VALUE   = 100;
    localparam int unsigned DEF_COFFEE_PRICE = 300;
    localparam int unsigned DEF_MAX_BALANCE  = 9900;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_BREW  = 2'd1,
        ST_DONE  = 2'd2,
        ST_RSVD  = 2'd3
    } state_t;

endpackage

// File: rtl/coffee_if.sv
// Button pulses in, display/status outputs back. The master side presses
// buttons; the slave side is the controller.
interface coffee_if;
    import coffee_pkg::*;

    logic             coin_pulse;
    logic             return_pulse;
    logic             coffee_pulse;
    logic [BAL_W-1:0] balance;
    logic [1:0]       state;
    logic [2:0]       anim_phase;
    logic             return_valid;
    logic [BAL_W-1:0] return_amount;
    logic             deny_pulse;

    modport master (
        output coin_pulse, return_pulse, coffee_pulse,
        input  balance, state, anim_phase, return_valid, return_amount, deny_pulse
    );

    modport slave (
        input  coin_pulse, return_pulse, coffee_pulse,
        output balance, state, anim_phase, return_valid, return_amount, deny_pulse
    );

endinterface

// File: rtl/coffee_brew_timer.sv
// Brew duration counter and animation phase generator. Counters sit at
// zero whenever the brew is not running, so each brew starts fresh.
module brew_timer #(
    parameter int unsigned BREW_CYCLES = 500_000_000,
    parameter int unsigned ANIM_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       run,
    output logic       done,
    output logic [2:0] anim_phase
);

    localparam int BW = (BREW_CYCLES > 1) ? $clog2(BREW_CYCLES) : 1;
    localparam int AW = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;

    logic [BW-1:0] brew_cnt;
    logic [AW-1:0] anim_cnt;
    logic          anim_tc;

    // Terminal count is combinational so the FSM leaves BREW on the last clock.
    assign done    = run && (brew_cnt == BW'(BREW_CYCLES - 1));
    assign anim_tc = (anim_cnt == AW'(ANIM_CYCLES - 1));

    // Brew/animation counters; phase wraps 5 -> 0.
    always_ff @(posedge clk) begin
        if (reset || start || !run || done) begin
            brew_cnt   <= '0;
            anim_cnt   <= '0;
            anim_phase <= 3'd0;
        end else begin
            brew_cnt <= brew_cnt + BW'(1);
            if (anim_tc) begin
                anim_cnt   <= '0;
                anim_phase <= (anim_phase == 3'd5) ? 3'd0 : anim_phase + 3'd1;
            end else begin
                anim_cnt <= anim_cnt + AW'(1);
            end
        end
    end

endmodule

// File: rtl/coffee_ctrl.sv
// Coffee vending controller: READY/BREW/DONE FSM plus the balance datapath.
// Every output is registered; a button pulse is answered one clock later.
module coffee_ctrl
    import coffee_pkg::*;
#(
    parameter int unsigned COIN_VALUE   = DEF_COIN_VALUE,
    parameter int unsigned COFFEE_PRICE = DEF_COFFEE_PRICE,
    parameter int unsigned MAX_BALANCE  = DEF_MAX_BALANCE,
    parameter int unsigned BREW_CYCLES  = 500_000_000,
    parameter int unsigned ANIM_CYCLES  = 50_000_000
) (
    input logic    clk,
    input logic    reset,
    coffee_if.slave bus
);

    state_t           state_q, state_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic [BAL_W-1:0] ramt_q, ramt_d;
    logic             rv_q, rv_d;
    logic             deny_q, deny_d;
    logic             brew_start;
    logic             brew_done;
    logic [2:0]       anim_phase;
    logic [BAL_W:0]   bal_plus_coin;

    // One extra bit so the ceiling test cannot wrap.
    assign bal_plus_coin = {1'b0, bal_q} + (BAL_W+1)'(COIN_VALUE);

    brew_timer #(
        .BREW_CYCLES (BREW_CYCLES),
        .ANIM_CYCLES (ANIM_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (brew_start),
        .run        (state_q == ST_BREW),
        .done       (brew_done),
        .anim_phase (anim_phase)
    );

    // Next state and next outputs; return beats coffee beats coin in READY.
    always_comb begin
        state_d    = state_q;
        bal_d      = bal_q;
        rv_d       = 1'b0;
        ramt_d     = '0;
        deny_d     = 1'b0;
        brew_start = 1'b0;
        case (state_q)
            ST_READY: begin
                if (bus.return_pulse) begin
                    rv_d   = 1'b1;
                    ramt_d = bal_q;
                    bal_d  = '0;
                end else if (bus.coffee_pulse) begin
                    if (bal_q >= BAL_W'(COFFEE_PRICE)) begin
                        bal_d      = bal_q - BAL_W'(COFFEE_PRICE);
                        state_d    = ST_BREW;
                        brew_start = 1'b1;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (bus.coin_pulse) begin
                    if (bal_plus_coin <= (BAL_W+1)'(MAX_BALANCE))
                        bal_d = bal_plus_coin[BAL_W-1:0];
                    else
                        deny_d = 1'b1;
                end
            end
            ST_BREW: begin
                if (bus.coin_pulse || bus.coffee_pulse || bus.return_pulse)
                    deny_d = 1'b1;
                if (brew_done)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_READY;
            default: state_d = ST_READY;
        endcase
    end

    // State and output registers; reset overrides every pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_READY;
            bal_q   <= '0;
            rv_q    <= 1'b0;
            ramt_q  <= '0;
            deny_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bal_q   <= bal_d;
            rv_q    <= rv_d;
            ramt_q  <= ramt_d;
            deny_q  <= deny_d;
        end
    end

    assign bus.balance       = bal_q;
    assign bus.state         = state_q;
    assign bus.anim_phase    = anim_phase;
    assign bus.return_valid  = rv_q;
    assign bus.return_amount = ramt_q;
    assign bus.deny_pulse    = deny_q;

endmodule
